// File: rtl/alu_arith_core_if.sv
// Operand, result and divider handshake bundle for the ALU arithmetic core.
// The master drives operands and start; the core (slave) drives all results.
interface alu_arith_core_if;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       start;
    logic [7:0] sum;
    logic       cout;
    logic [1:0] cmp;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    modport master (
        output a, b, cin, start,
        input  sum, cout, cmp, quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  a, b, cin, start,
        output sum, cout, cmp, quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/alu_arith_core.sv
// ALU arithmetic core: combinational ripple adder and magnitude comparator,
// plus an 8-cycle restoring divider with start/done handshake.
//
// state  | meaning
// IDLE   | waiting for start; last results held on quotient/remainder
// RUN    | one restoring-division iteration per clock, 8 in total
module alu_arith_core (
    input  logic            clk,
    input  logic            reset,
    alu_arith_core_if.slave bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [8:0] carry;
    logic [7:0] sum_w;

    assign carry[0] = bus.cin;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_fa
            assign sum_w[gi]    = bus.a[gi] ^ bus.b[gi] ^ carry[gi];
            assign carry[gi+1]  = (bus.a[gi] & bus.b[gi]) |
                                  (carry[gi] & (bus.a[gi] ^ bus.b[gi]));
        end
    endgenerate

    assign bus.sum  = sum_w;
    assign bus.cout = carry[8];

    assign bus.cmp = (bus.a == bus.b) ? 2'b00 :
                     (bus.a >  bus.b) ? 2'b01 : 2'b10;

    logic [0:0] state_q,     state_d;
    logic [2:0] cnt_q,       cnt_d;
    logic [7:0] dividend_q,  dividend_d;
    logic [7:0] divisor_q,   divisor_d;
    logic [8:0] rem_q,       rem_d;
    logic [7:0] qsr_q,       qsr_d;
    logic [7:0] quotient_q,  quotient_d;
    logic [7:0] remainder_q, remainder_d;
    logic       done_q,      done_d;
    logic       dbz_q,       dbz_d;

    logic [9:0] rem_sh;
    logic [8:0] trial;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        qsr_d       = qsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        // Next dividend bit shifts into the partial remainder before the trial subtract.
        rem_sh = {rem_q, dividend_q[7]};
        trial  = rem_sh[8:0] - {1'b0, divisor_q};

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dividend_d = bus.a;
                    divisor_d  = bus.b;
                    rem_d      = 9'd0;
                    qsr_d      = 8'd0;
                    cnt_d      = 3'd0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                dividend_d = {dividend_q[6:0], 1'b0};
                if (rem_sh >= {2'b00, divisor_q}) begin
                    rem_d = trial;
                    qsr_d = {qsr_q[6:0], 1'b1};
                end else begin
                    rem_d = rem_sh[8:0];
                    qsr_d = {qsr_q[6:0], 1'b0};
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    quotient_d  = qsr_d;
                    remainder_d = rem_d[7:0];
                    dbz_d       = (divisor_q == 8'd0);
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            dividend_q  <= 8'd0;
            divisor_q   <= 8'd0;
            rem_q       <= 9'd0;
            qsr_q       <= 8'd0;
            quotient_q  <= 8'd0;
            remainder_q <= 8'd0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            qsr_q       <= qsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.busy        = (state_q == S_RUN);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_arith_core.sv
// Self-checking bench for alu_arith_core: adder/comparator against arithmetic
// reference, divider timing and results against integer division.
module tb_alu_arith_core;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    alu_arith_core_if bus ();

    alu_arith_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        int s;
        s = int'(x) + int'(y) + int'(c);
        return s[8:0];
    endfunction

    function automatic logic [1:0] ref_cmp(input logic [7:0] x, input logic [7:0] y);
        if (x == y) return 2'b00;
        if (x > y)  return 2'b01;
        return 2'b10;
    endfunction

    // {div_by_zero, quotient, remainder}
    function automatic logic [16:0] ref_div(input logic [7:0] x, input logic [7:0] y);
        if (y == 8'd0) return {1'b1, 8'hFF, x};
        return {1'b0, 8'(x / y), 8'(x % y)};
    endfunction

    task automatic check_comb(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c);
        bus.a   = x;
        bus.b   = y;
        bus.cin = c;
        #1;
        check({tag, "_add"}, {bus.cout, bus.sum}, ref_add(x, y, c));
        check({tag, "_cmp"}, bus.cmp, ref_cmp(x, y));
    endtask

    // Entered #1 after a rising edge with the divider idle; leaves it the same way.
    task automatic do_div(input logic [7:0] da, input logic [7:0] db);
        logic [16:0] exp;
        exp       = ref_div(da, db);
        bus.a     = da;
        bus.b     = db;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("div_accept_busy", bus.busy, 1);
        check("div_accept_done", bus.done, 0);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin
                bus.a = 8'($urandom);
                bus.b = 8'($urandom);
            end
            if (i < 8) begin
                check("div_run_busy", bus.busy, 1);
                check("div_run_done", bus.done, 0);
            end else begin
                check("div_done", bus.done, 1);
                check("div_end_busy", bus.busy, 0);
                check("div_quotient", bus.quotient, exp[15:8]);
                check("div_remainder", bus.remainder, exp[7:0]);
                check("div_dbz", bus.div_by_zero, exp[16]);
            end
        end
        @(posedge clk); #1;
        check("div_done_clear", bus.done, 0);
        check("div_hold_q", bus.quotient, exp[15:8]);
    endtask

    initial begin
        logic saw_done;
        reset     = 1'b0;
        bus.a     = 8'd0;
        bus.b     = 8'd0;
        bus.cin   = 1'b0;
        bus.start = 1'b0;
        #2;
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        #10 reset = 1'b1;

        check_comb("add_0f_01", 8'h0F, 8'h01, 1'b0);
        check_comb("add_ff_01", 8'hFF, 8'h01, 1'b1);
        check_comb("cmp_eq", 8'd5, 8'd5, 1'b0);
        check_comb("cmp_gt", 8'd200, 8'd7, 1'b0);
        check_comb("cmp_lt", 8'd7, 8'd200, 1'b0);
        for (int k = 0; k < 300; k++)
            check_comb("rand", 8'($urandom), 8'($urandom), 1'($urandom));
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                bus.a = 8'(i);
                bus.b = 8'(j);
                #1;
                check("cmp_sweep", bus.cmp, ref_cmp(8'(i), 8'(j)));
            end
        end

        @(posedge clk); #1;
        do_div(8'd100, 8'd7);
        do_div(8'd37, 8'd0);
        do_div(8'd9, 8'd3);
        for (int k = 0; k < 25; k++)
            do_div(8'($urandom), (k % 6 == 0) ? 8'd0 : 8'($urandom_range(1, 255)));

        // Start held high: a new division is accepted every 9 cycles.
        bus.a     = 8'd255;
        bus.b     = 8'd16;
        bus.start = 1'b1;
        @(posedge clk); #1;
        check("cont_accept_busy", bus.busy, 1);
        for (int d = 0; d < 3; d++) begin
            for (int i = 1; i <= 8; i++) begin
                @(posedge clk); #1;
                if (i == 3) begin
                    bus.a = 8'($urandom);
                    bus.b = 8'($urandom);
                end
                if (i < 8) begin
                    check("cont_run_done", bus.done, 0);
                end else begin
                    check("cont_done", bus.done, 1);
                    check("cont_quotient", bus.quotient, 15);
                    check("cont_remainder", bus.remainder, 15);
                    bus.a = 8'd255;
                    bus.b = 8'd16;
                end
            end
            @(posedge clk); #1;
            check("cont_reaccept_done", bus.done, 0);
            check("cont_reaccept_busy", bus.busy, 1);
        end
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("cont_last_done", bus.done, 1);
        check("cont_last_quotient", bus.quotient, 15);

        // Reset during iteration 4 of 200/3.
        bus.a     = 8'd200;
        bus.b     = 8'd3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_quotient", bus.quotient, 0);
        check("midrst_remainder", bus.remainder, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        #2 reset = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 0);
        do_div(8'd200, 8'd3);
        check("midrst_new_q", bus.quotient, 66);
        check("midrst_new_r", bus.remainder, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
